// File: rtl/pipelined_control_unit_if.sv
// rtl/pipelined_control_unit_if.sv - ID-stage control bundle interface
//
// Purpose: groups the signals between the IF/ID register, the EX stage and
// the control unit.
//   master : pipeline side; drives ID/EX inputs, receives control outputs.
//   slave  : control unit side.
// Signals:
//   id_valid, opcode[6:0], id_rs1, id_rs2    ID-stage instruction fields
//   ex_rd, ex_mem_read                       instruction currently in EX
//   redirect                                 taken branch/jump from EX
//   ctl_*                                    registered ID/EX control bits
//   pc_write, if_id_write, if_id_flush       combinational pipeline enables
interface pipelined_control_unit_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [6:0]            opcode;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  redirect;

  logic                  ctl_valid;
  logic                  ctl_mem_read;
  logic                  ctl_mem_to_reg;
  logic                  ctl_mem_write;
  logic                  ctl_reg_write;
  logic                  ctl_branch;
  logic                  ctl_jump;
  logic                  ctl_alu_src;
  logic [1:0]            ctl_alu_op;
  logic                  ctl_illegal;
  logic                  pc_write;
  logic                  if_id_write;
  logic                  if_id_flush;

  modport master (
    output id_valid, opcode, id_rs1, id_rs2, ex_rd, ex_mem_read, redirect,
    input  ctl_valid, ctl_mem_read, ctl_mem_to_reg, ctl_mem_write,
           ctl_reg_write, ctl_branch, ctl_jump, ctl_alu_src, ctl_alu_op,
           ctl_illegal, pc_write, if_id_write, if_id_flush
  );

  modport slave (
    input  id_valid, opcode, id_rs1, id_rs2, ex_rd, ex_mem_read, redirect,
    output ctl_valid, ctl_mem_read, ctl_mem_to_reg, ctl_mem_write,
           ctl_reg_write, ctl_branch, ctl_jump, ctl_alu_src, ctl_alu_op,
           ctl_illegal, pc_write, if_id_write, if_id_flush
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - ID-stage decode, load-use stall and flush control
//
// Purpose: decodes the ID-stage opcode into the control bundle and registers
// it into the ID/EX control register; inserts load-use bubbles and sequences
// IF/ID flushes after a taken branch/jump.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   bus (slave)    ID/EX inputs, registered ctl_* bundle, pc_write,
//                  if_id_write, if_id_flush
//   stall_cnt      (CTRL_PERF_CNT_EN only) saturating count of pc_write=0 cycles
//   flush_cnt      (CTRL_PERF_CNT_EN only) saturating count of if_id_flush=1 cycles
// Optional build macro: CTRL_PERF_CNT_EN
module pipelined_control_unit #(
  parameter int REG_ADDR_W       = 5,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int FLUSH_CYCLES     = 1
) (
  input  logic clk,
  input  logic rst_n,
  pipelined_control_unit_if.slave bus
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  // The first bubble/flush cycle is spent in RUN (or on the redirect itself),
  // so the counter only covers the remaining cycles.
  localparam logic [1:0] STALL_RELOAD =
    (LOAD_USE_BUBBLES > 1) ? 2'(LOAD_USE_BUBBLES - 2) : 2'd0;
  localparam logic [1:0] FLUSH_RELOAD =
    (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  typedef struct packed {
    logic       valid;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
    logic       illegal;
  } ctl_t;

  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  ctl_t ctl_q, ctl_d;

  logic [REG_ADDR_W-1:0] rs1, rs2, ex_rd;
  logic [8:0] fields;
  logic       unknown_op, rs1_used, rs2_used, hazard;
  logic       load_dec, pc_write_c, if_id_write_c, if_id_flush_c;

  assign rs1   = bus.id_rs1;
  assign rs2   = bus.id_rs2;
  assign ex_rd = bus.ex_rd;

  // fields = {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, alu_op}
  always_comb begin
    fields     = 9'b0;
    unknown_op = 1'b0;
    rs1_used   = 1'b1;
    rs2_used   = 1'b0;
    case (bus.opcode)
      OP_LW:   fields = 9'b1111000_00;
      OP_SW:   begin fields = 9'b1000100_00; rs2_used = 1'b1; end
      OP_BEQ:  begin fields = 9'b0000010_01; rs2_used = 1'b1; end
      OP_R:    begin fields = 9'b0010000_10; rs2_used = 1'b1; end
      OP_IALU: fields = 9'b1010000_11;
      OP_JAL:  begin fields = 9'b0010001_00; rs1_used = 1'b0; end
      OP_JALR: fields = 9'b1010001_00;
      OP_LUI:  begin fields = 9'b1010000_00; rs1_used = 1'b0; end
      default: unknown_op = 1'b1;
    endcase
  end

  assign hazard = bus.ex_mem_read & bus.id_valid & (ex_rd != '0) &
                  ((rs1_used & (ex_rd == rs1)) | (rs2_used & (ex_rd == rs2)));

  // Next state and pipeline enables; redirect outranks everything.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    load_dec      = 1'b0;
    pc_write_c    = 1'b1;
    if_id_write_c = 1'b1;
    if_id_flush_c = 1'b0;
    if (bus.redirect) begin
      if_id_flush_c = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_RELOAD;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            if (LOAD_USE_BUBBLES > 1) begin
              state_d = STALL;
              cnt_d   = STALL_RELOAD;
            end
          end else begin
            load_dec = 1'b1;
          end
        end
        STALL: begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          if (cnt_q == 2'd0) state_d = RUN;
          else               cnt_d   = cnt_q - 2'd1;
        end
        FLUSH: begin
          if_id_flush_c = 1'b1;
          if (cnt_q == 2'd0) state_d = RUN;
          else               cnt_d   = cnt_q - 2'd1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    ctl_d = '0;
    if (load_dec) begin
      ctl_d = {bus.id_valid, fields, unknown_op & bus.id_valid};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
    end
  end

  assign bus.ctl_valid      = ctl_q.valid;
  assign bus.ctl_alu_src    = ctl_q.alu_src;
  assign bus.ctl_mem_to_reg = ctl_q.mem_to_reg;
  assign bus.ctl_reg_write  = ctl_q.reg_write;
  assign bus.ctl_mem_read   = ctl_q.mem_read;
  assign bus.ctl_mem_write  = ctl_q.mem_write;
  assign bus.ctl_branch     = ctl_q.branch;
  assign bus.ctl_jump       = ctl_q.jump;
  assign bus.ctl_alu_op     = ctl_q.alu_op;
  assign bus.ctl_illegal    = ctl_q.illegal;
  assign bus.pc_write       = pc_write_c;
  assign bus.if_id_write    = if_id_write_c;
  assign bus.if_id_flush    = if_id_flush_c;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write_c && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (if_id_flush_c && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - directed bench for pipelined_control_unit
module tb_pipelined_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  pipelined_control_unit_if #(.REG_ADDR_W(5)) if_a ();
  pipelined_control_unit_if #(.REG_ADDR_W(5)) if_b ();

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;
`endif

  // A: one load-use bubble, one flush cycle
  pipelined_control_unit #(.REG_ADDR_W(5), .LOAD_USE_BUBBLES(1), .FLUSH_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave)
`ifdef CTRL_PERF_CNT_EN
    , .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
`endif
  );

  // B: three load-use bubbles, two flush cycles
  pipelined_control_unit #(.REG_ADDR_W(5), .LOAD_USE_BUBBLES(3), .FLUSH_CYCLES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave)
`ifdef CTRL_PERF_CNT_EN
    , .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
`endif
  );

  // {valid, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, alu_op, illegal}
  logic [10:0] ctl_a, ctl_b;
  logic [2:0]  comb_a, comb_b;
  assign ctl_a = {if_a.ctl_valid, if_a.ctl_alu_src, if_a.ctl_mem_to_reg, if_a.ctl_reg_write,
                  if_a.ctl_mem_read, if_a.ctl_mem_write, if_a.ctl_branch, if_a.ctl_jump,
                  if_a.ctl_alu_op, if_a.ctl_illegal};
  assign ctl_b = {if_b.ctl_valid, if_b.ctl_alu_src, if_b.ctl_mem_to_reg, if_b.ctl_reg_write,
                  if_b.ctl_mem_read, if_b.ctl_mem_write, if_b.ctl_branch, if_b.ctl_jump,
                  if_b.ctl_alu_op, if_b.ctl_illegal};
  // {pc_write, if_id_write, if_id_flush}
  assign comb_a = {if_a.pc_write, if_a.if_id_write, if_a.if_id_flush};
  assign comb_b = {if_b.pc_write, if_b.if_id_write, if_b.if_id_flush};

  localparam logic [2:0] N = 3'b110;
  localparam logic [2:0] S = 3'b000;
  localparam logic [2:0] F = 3'b111;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, BEQ = 7'b1100011, RR = 7'b0110011;
  localparam logic [6:0] IA = 7'b0010011, JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111;
  localparam logic [6:0] BAD = 7'b1111111;

  localparam logic [10:0] C_LW   = 11'b1_1111000_00_0;
  localparam logic [10:0] C_SW   = 11'b1_1000100_00_0;
  localparam logic [10:0] C_BEQ  = 11'b1_0000010_01_0;
  localparam logic [10:0] C_R    = 11'b1_0010000_10_0;
  localparam logic [10:0] C_IA   = 11'b1_1010000_11_0;
  localparam logic [10:0] C_JAL  = 11'b1_0010001_00_0;
  localparam logic [10:0] C_JALR = 11'b1_1010001_00_0;
  localparam logic [10:0] C_LUI  = 11'b1_1010000_00_0;
  localparam logic [10:0] C_BAD  = 11'b1_0000000_00_1;
  localparam logic [10:0] C_0    = 11'b0;

  logic [6:0]  dec_op  [9];
  logic [10:0] dec_exp [9];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [6:0] op, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] xrd, input logic xmr,
                        input logic redir);
    if_a.id_valid = v;   if_b.id_valid = v;
    if_a.opcode = op;    if_b.opcode = op;
    if_a.id_rs1 = r1;    if_b.id_rs1 = r1;
    if_a.id_rs2 = r2;    if_b.id_rs2 = r2;
    if_a.ex_rd = xrd;    if_b.ex_rd = xrd;
    if_a.ex_mem_read = xmr; if_b.ex_mem_read = xmr;
    if_a.redirect = redir;  if_b.redirect = redir;
  endtask

  // Checks enables before the edge, then the registered bundle after it.
  task automatic cyc(input string tag, input logic [2:0] ca, input logic [2:0] cb,
                     input logic [10:0] xa, input logic [10:0] xb);
    #1;
    chk({tag, ".comb_a"}, 32'(comb_a), 32'(ca));
    chk({tag, ".comb_b"}, 32'(comb_b), 32'(cb));
    @(posedge clk);
    #1;
    chk({tag, ".ctl_a"}, 32'(ctl_a), 32'(xa));
    chk({tag, ".ctl_b"}, 32'(ctl_b), 32'(xb));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    dec_op[0] = LW;   dec_exp[0] = C_LW;
    dec_op[1] = SW;   dec_exp[1] = C_SW;
    dec_op[2] = BEQ;  dec_exp[2] = C_BEQ;
    dec_op[3] = RR;   dec_exp[3] = C_R;
    dec_op[4] = IA;   dec_exp[4] = C_IA;
    dec_op[5] = JAL;  dec_exp[5] = C_JAL;
    dec_op[6] = JALR; dec_exp[6] = C_JALR;
    dec_op[7] = LUI;  dec_exp[7] = C_LUI;
    dec_op[8] = BAD;  dec_exp[8] = C_BAD;

    // Reset state
    set_in(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.ctl_a", 32'(ctl_a), 32'(C_0));
    chk("reset.ctl_b", 32'(ctl_b), 32'(C_0));
    rst_n = 1'b1;

    // Decode table, one edge latency
    for (int i = 0; i < 9; i++) begin
      set_in(1'b1, dec_op[i], 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
      cyc($sformatf("dec%0d", i), N, N, dec_exp[i], dec_exp[i]);
    end
    // Unknown opcode without id_valid is not illegal
    set_in(1'b0, BAD, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    cyc("inval", N, N, C_0, C_0);

    // Load-use on rs1: A bubbles once, B three times
    set_in(1'b1, LW, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0);
    cyc("hz0", S, S, C_0, C_0);
    set_in(1'b1, LW, 5'd5, 5'd2, 5'd5, 1'b0, 1'b0);
    cyc("hz1", N, S, C_LW, C_0);
    cyc("hz2", N, S, C_LW, C_0);
    cyc("hz3", N, N, C_LW, C_LW);

    // No hazard: ex_rd=0, jal ignores rs1, I-ALU ignores rs2
    set_in(1'b1, LW, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    cyc("rd0", N, N, C_LW, C_LW);
    set_in(1'b1, JAL, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0);
    cyc("jal", N, N, C_JAL, C_JAL);
    set_in(1'b1, IA, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0);
    cyc("ia_rs2", N, N, C_IA, C_IA);

    // sw rs2 hazard, then redirect on the second bubble cycle abandons STALL
    set_in(1'b1, SW, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0);
    cyc("sw_hz", S, S, C_0, C_0);
    set_in(1'b1, SW, 5'd1, 5'd5, 5'd5, 1'b0, 1'b1);
    cyc("redir0", F, F, C_0, C_0);
    set_in(1'b1, RR, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    cyc("redir1", N, F, C_R, C_0);
    cyc("redir2", N, N, C_R, C_R);

    // Asynchronous reset clears a non-zero bundle without a clock edge
    set_in(1'b1, LW, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    cyc("pre_rst", N, N, C_LW, C_LW);
    rst_n = 1'b0;
    #1;
    chk("arst.ctl_a", 32'(ctl_a), 32'(C_0));
    chk("arst.ctl_b", 32'(ctl_b), 32'(C_0));
    #1 rst_n = 1'b1;

    // Reset mid-FLUSH returns B to RUN
    set_in(1'b1, LW, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
    cyc("fl_enter", F, F, C_0, C_0);
    set_in(1'b1, RR, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("fl_rst.ctl_b", 32'(ctl_b), 32'(C_0));
    #1 rst_n = 1'b1;
    cyc("post_rst", N, N, C_R, C_R);

    // Two load-use hazards back to back
    for (int h = 0; h < 2; h++) begin
      set_in(1'b1, LW, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0);
      cyc($sformatf("p%0d_0", h), S, S, C_0, C_0);
      set_in(1'b1, LW, 5'd5, 5'd2, 5'd5, 1'b0, 1'b0);
      cyc($sformatf("p%0d_1", h), N, S, C_LW, C_0);
      cyc($sformatf("p%0d_2", h), N, S, C_LW, C_0);
    end
`ifdef CTRL_PERF_CNT_EN
    chk("stall_cnt_b", stall_cnt_b, 32'd6);
    chk("flush_cnt_b", flush_cnt_b, 32'd0);
    chk("stall_cnt_a", stall_cnt_a, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Next-generation control path for the RISC-V core. It decodes the ID-stage opcode into the full control bundle and registers it into the ID/EX control register. It integrates load-use hazard detection with a parametrised bubble count, and taken-branch/jump flush sequencing. It sits between the IF/ID register and the EX stage, and drives the PC and IF/ID write enables.

Parameters:
REG_ADDR_W, 5, register-index width.
LOAD_USE_BUBBLES, 1, bubble cycles inserted per load-use hazard (legal 1..4).
FLUSH_CYCLES, 1, cycles of flush per taken branch/jump (legal 1..4).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
id_valid  in  1  IF/ID holds a valid instruction.
opcode  in  7  ID-stage opcode.
id_rs1  in  REG_ADDR_W  ID-stage rs1 index.
id_rs2  in  REG_ADDR_W  ID-stage rs2 index.
ex_rd  in  REG_ADDR_W  rd of the instruction currently in EX.
ex_mem_read  in  1  EX instruction is a load.
redirect  in  1  EX resolved a taken branch or jump.
ctl_valid, ctl_mem_read, ctl_mem_to_reg, ctl_mem_write, ctl_reg_write, ctl_branch, ctl_jump, ctl_alu_src  out  1 each  registered ID/EX control bits.
ctl_alu_op  out  2  registered ALU op class.
ctl_illegal  out  1  registered flag: valid instruction had an unknown opcode.
pc_write  out  1  combinational PC enable.
if_id_write  out  1  combinational IF/ID enable.
if_id_flush  out  1  combinational IF/ID clear.

Behaviour:
- Reset: state=RUN, counter=0, all ctl_* = 0. Async assertion at any time (including mid-STALL/FLUSH) clears immediately; first post-reset edge behaves as RUN.
- Decode (fields: alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, alu_op):
  - 0000011 lw: 1,1,1,1,0,0,0,00.
  - 0100011 sw: 1,0,0,0,1,0,0,00.
  - 1100011 beq: 0,0,0,0,0,1,0,01.
  - 0110011 R: 0,0,1,0,0,0,0,10.
  - 0010011 I-ALU: 1,0,1,0,0,0,0,11.
  - 1101111 jal: 0,0,1,0,0,0,1,00.
  - 1100111 jalr: 1,0,1,0,0,0,1,00.
  - 0110111 lui: 1,0,1,0,0,0,0,00.
  - Other: all 0, illegal=1. illegal is only asserted when id_valid=1.
- rs2 is used only by R, sw and beq; rs1 is used by all except jal and lui.
- hazard = ex_mem_read & id_valid & (ex_rd!=0) & ((rs1 used & ex_rd==id_rs1) | (rs2 used & ex_rd==id_rs2)).
- Bubble = all ctl_* registered to 0, including ctl_valid.
- Priority each cycle: redirect > STALL/FLUSH state > hazard > normal.
- States:
  - RUN, normal: ctl_* <= decode with ctl_valid=id_valid; pc_write=if_id_write=1, if_id_flush=0.
  - RUN, hazard: bubble; pc_write=if_id_write=0. If LOAD_USE_BUBBLES>1, go to STALL with counter=LOAD_USE_BUBBLES-2.
  - STALL: bubble; pc_write=if_id_write=0. If counter==0 go to RUN, else decrement. Hazard is not re-evaluated until back in RUN.
  - Any state, redirect=1: bubble; if_id_flush=1; pc_write=1; if_id_write=1. Abandons any STALL. If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-2, else RUN.
  - FLUSH: bubble; if_id_flush=1; pc_write=if_id_write=1. If counter==0 go to RUN, else decrement. A redirect during FLUSH reloads the counter.
- Latency: decode result appears on ctl_* one edge after sampling.

Optional Feature:
CTRL_PERF_CNT_EN:
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0]. They count cycles with pc_write=0 and cycles with if_id_flush=1 respectively, saturate at 32'hFFFFFFFF, and are cleared by rst_n.
- Undefined: neither port nor logic exists.

Test Plan:
- Reset, then id_valid=1 with opcodes lw, sw, beq, R, I-ALU, jal, jalr, lui, 1111111 -> ctl_* match the decode table one edge later; ctl_illegal=1 only for 1111111.
- ex_mem_read=1, ex_rd=5, id_rs1=5, lw in ID, LOAD_USE_BUBBLES=1 -> one bubble cycle with pc_write=if_id_write=0, then normal decode.
- Same with LOAD_USE_BUBBLES=3 -> exactly 3 bubble cycles; ex_rd=0 or jal in ID -> no stall.
- redirect=1 during cycle 2 of STALL with FLUSH_CYCLES=2 -> STALL abandoned; if_id_flush=1 for 2 cycles; ctl_valid=0 for 2 cycles.
- Deassert rst_n mid-FLUSH -> all ctl_* = 0 immediately; RUN decode on the first edge after release.
- With CTRL_PERF_CNT_EN, two hazards of 3 bubbles each -> stall_cnt=6; flush_cnt=0.
